mux_sel_arbiter: RTL

Round-robin arbiter that owns the select lines of the 4:1 mux datapath. Four requesters compete for the shared mux output. The block grants one requester at a time and drives `s1`/`s0` so the mux forwards the granted input. A grant is bounded by a hold limit so that no requester can starve the others.

---
 rtl/mux_sel_arbiter_if.sv | 21 ++
 rtl/mux_sel_arbiter.sv | 120 ++++++++++++
 2 files changed

// File: rtl/mux_sel_arbiter_if.sv
// Bundle of request/grant and mux-select signals shared between the requesters
// and the round-robin select arbiter.
interface mux_sel_arbiter_if;
  logic [3:0] req;
  logic       done;
  logic       s1;
  logic       s0;
  logic [3:0] gnt;
  logic       busy;
  logic       timeout;

  modport master (
    output req, done,
    input  s1, s0, gnt, busy, timeout
  );

  modport slave (
    input  req, done,
    output s1, s0, gnt, busy, timeout
  );
endinterface

// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter owning the 4:1 mux select lines; each grant is bounded
// by MAX_HOLD consecutive cycles so no requester can starve the others.
module mux_sel_arbiter #(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  mux_sel_arbiter_if.slave   bus
);

  localparam int unsigned CW = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] HOLD_LIMIT = CW'(MAX_HOLD);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t        state, state_n;
  logic [1:0]    idx, idx_n;
  logic [1:0]    ptr, ptr_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0]    gnt, gnt_n;
  logic          busy, busy_n;
  logic          timeout, timeout_n;

  logic          win_found;
  logic [1:0]    win;
  logic          at_limit;
  logic          rel;

  // First asserted request scanning upward from ptr, wrapping modulo 4.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    win_found = 1'b0;
    win       = ptr;
    for (int i = 0; i < 4; i++) begin
      logic [1:0] cand;
      cand = ptr + 2'(i);
      if (!win_found && bus.req[cand]) begin
        win_found = 1'b1;
        win       = cand;
      end
    end
  end

  assign at_limit = (cnt == HOLD_LIMIT);
  assign rel      = bus.done || !bus.req[idx] || at_limit;

  always_comb begin
    state_n   = state;
    idx_n     = idx;
    ptr_n     = ptr;
    cnt_n     = cnt;
    gnt_n     = gnt;
    busy_n    = busy;
    timeout_n = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (win_found) begin
          state_n = S_GRANT;
          idx_n   = win;
          gnt_n   = 4'b0001 << win;
          busy_n  = 1'b1;
          cnt_n   = CW'(1);
          ptr_n   = win + 2'd1;
        end
      end
      S_GRANT: begin
        // Only a forced release pulses timeout; done or a dropped request wins.
        timeout_n = at_limit && !bus.done && bus.req[idx];
        if (!rel) begin
          cnt_n = cnt + CW'(1);
        end else if (win_found) begin
          idx_n = win;
          gnt_n = 4'b0001 << win;
          busy_n = 1'b1;
          cnt_n = CW'(1);
          ptr_n = win + 2'd1;
        end else begin
          // idx is kept so the mux keeps forwarding the last grantee.
          state_n = S_IDLE;
          gnt_n   = 4'b0000;
          busy_n  = 1'b0;
          cnt_n   = '0;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      idx     <= 2'd0;
      ptr     <= 2'd0;
      cnt     <= '0;
      gnt     <= 4'b0000;
      busy    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      ptr     <= ptr_n;
      cnt     <= cnt_n;
      gnt     <= gnt_n;
      busy    <= busy_n;
      timeout <= timeout_n;
    end
  end

  assign bus.s1      = idx[1];
  assign bus.s0      = idx[0];
  assign bus.gnt     = gnt;
  assign bus.busy    = busy;
  assign bus.timeout = timeout;

endmodule
